// File: rtl/store_write_master_if.sv
// rtl/store_write_master_if.sv - store request and Avalon-style write bus bundle
interface store_write_master_if;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] address;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;

   modport master (
      input  start, size, addr, data, waitrequest,
      output busy, done, err, address, write, writedata, byteenable
   );

   modport slave (
      output start, size, addr, data, waitrequest,
      input  busy, done, err, address, write, writedata, byteenable
   );
endinterface

// File: rtl/store_write_master.sv
// rtl/store_write_master.sv - SB/SH/SW lane alignment and write hold with stall timeout
module store_write_master #(
   parameter int TIMEOUT = 255
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   store_write_master_if.master   io_bus
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic          r_err;
   logic [31:0]   r_address;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;

   logic          w_legal;
   logic [3:0]    w_be;
   logic [31:0]   w_wd;
   logic [CW-1:0] w_cnt_inc;
   logic          w_timeout;

   always_comb begin
      w_legal = 1'b1;
      w_be    = 4'b0000;
      w_wd    = 32'h0;
      case (io_bus.size)
         2'b00: begin
            w_be = 4'b0001 << io_bus.addr[1:0];
            w_wd = {4{io_bus.data[7:0]}};
         end
         2'b01: begin
            w_be    = io_bus.addr[1] ? 4'b1100 : 4'b0011;
            w_wd    = {2{io_bus.data[15:0]}};
            w_legal = ~io_bus.addr[0];
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_wd    = io_bus.data;
            w_legal = (io_bus.addr[1:0] == 2'b00);
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Saturating stall count; abort on the edge that would make it reach TIMEOUT.
   assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
   assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TMO);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_address <= 32'h0;
         r_wdata   <= 32'h0;
         r_be      <= 4'b0000;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  if (w_legal) begin
                     r_state   <= S_WRITE;
                     r_cnt     <= '0;
                     r_address <= {io_bus.addr[31:2], 2'b00};
                     r_wdata   <= w_wd;
                     r_be      <= w_be;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            default: begin
               if (!io_bus.waitrequest) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
         endcase
      end
   end

   assign io_bus.busy       = (r_state == S_WRITE);
   assign io_bus.write      = (r_state == S_WRITE);
   assign io_bus.done       = r_done;
   assign io_bus.err        = r_err;
   assign io_bus.address    = r_address;
   assign io_bus.writedata  = r_wdata;
   assign io_bus.byteenable = r_be;
endmodule
